// File: rtl/nes_flash_rd_ctrl.sv
// Read-only controller for the 8-bit parallel NOR flash holding PRG/CHR images.
// Sequences the flash reset pin and runs timed async reads, with a one-entry tag for repeat reads.
//
// state        | meaning
// S_INIT_LOW   | FL_RST_N held low, cnt counts up to RST_LOW_CYC-1
// S_INIT_RECOV | FL_RST_N high, recovery down-count before first access
// S_IDLE       | ready for requests; tag hits answered here
// S_ACCESS     | CE_N/OE_N low, down-count to DQ sample
module nes_flash_rd_ctrl #(
   parameter int ACC_CYC     = 5,
   parameter int RST_LOW_CYC = 25,
   parameter int RECOV_CYC   = 3,
   parameter int HIT_EN      = 1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req,
   input  logic [22:0] i_fl_addr,
   input  logic        i_inval,
   output logic [7:0]  o_rdata,
   output logic        o_ready,
   output logic        o_busy,
   output logic [22:0] o_FL_ADDR,
   input  logic [7:0]  i_FL_DQ,
   output logic        o_FL_CE_N,
   output logic        o_FL_OE_N,
   output logic        o_FL_WE_N,
   output logic        o_FL_RST_N,
   output logic        o_FL_WP_N
);

   localparam int MAX_AB = (ACC_CYC > RST_LOW_CYC) ? ACC_CYC : RST_LOW_CYC;
   localparam int MAX_C  = (MAX_AB > RECOV_CYC) ? MAX_AB : RECOV_CYC;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] ACC_LD       = CW'(ACC_CYC - 1);
   localparam logic [CW-1:0] RECOV_LD     = CW'(RECOV_CYC - 1);
   localparam logic [CW-1:0] RST_LOW_LAST = CW'(RST_LOW_CYC - 1);
   localparam logic [CW-1:0] CNT_ZERO     = '0;

   typedef enum logic [1:0] {
      S_INIT_LOW   = 2'd0,
      S_INIT_RECOV = 2'd1,
      S_IDLE       = 2'd2,
      S_ACCESS     = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [22:0]   fl_addr_q, fl_addr_d;
   logic          ce_n_q, ce_n_d;
   logic          fl_rst_n_q, fl_rst_n_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic [22:0]   tag_q, tag_d;
   logic          valid_q, valid_d;
   logic          inv_pend_q, inv_pend_d;
   logic          hit;

   assign hit = (HIT_EN != 0) && valid_q && !i_inval && (i_fl_addr == tag_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fl_addr_d  = fl_addr_q;
      ce_n_d     = ce_n_q;
      fl_rst_n_d = fl_rst_n_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      busy_d     = busy_q;
      tag_d      = tag_q;
      valid_d    = valid_q;
      inv_pend_d = inv_pend_q;
      unique case (state_q)
         // Reset leaves cnt at zero, so the low phase counts up to its terminal value.
         S_INIT_LOW: begin
            if (i_inval) valid_d = 1'b0;
            if (cnt_q == RST_LOW_LAST) begin
               fl_rst_n_d = 1'b1;
               cnt_d      = RECOV_LD;
               state_d    = S_INIT_RECOV;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_INIT_RECOV: begin
            if (i_inval) valid_d = 1'b0;
            if (cnt_q == CNT_ZERO) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_IDLE: begin
            if (i_inval) valid_d = 1'b0;
            if (i_req) begin
               if (hit) begin
                  ready_d = 1'b1;
               end else begin
                  fl_addr_d = i_fl_addr;
                  ce_n_d    = 1'b0;
                  busy_d    = 1'b1;
                  cnt_d     = ACC_LD;
                  state_d   = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (cnt_q == CNT_ZERO) begin
               rdata_d    = i_FL_DQ;
               tag_d      = fl_addr_q;
               valid_d    = !(inv_pend_q || i_inval);
               inv_pend_d = 1'b0;
               ce_n_d     = 1'b1;
               ready_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (i_inval) inv_pend_d = 1'b1;
            end
         end
         default: state_d = S_INIT_LOW;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_INIT_LOW;
         cnt_q      <= '0;
         fl_addr_q  <= '0;
         ce_n_q     <= 1'b1;
         fl_rst_n_q <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
         tag_q      <= '0;
         valid_q    <= 1'b0;
         inv_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fl_addr_q  <= fl_addr_d;
         ce_n_q     <= ce_n_d;
         fl_rst_n_q <= fl_rst_n_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         tag_q      <= tag_d;
         valid_q    <= valid_d;
         inv_pend_q <= inv_pend_d;
      end
   end

   assign o_rdata    = rdata_q;
   assign o_ready    = ready_q;
   assign o_busy     = busy_q;
   assign o_FL_ADDR  = fl_addr_q;
   assign o_FL_CE_N  = ce_n_q;
   assign o_FL_OE_N  = ce_n_q;
   assign o_FL_WE_N  = 1'b1;
   assign o_FL_RST_N = fl_rst_n_q;
   assign o_FL_WP_N  = 1'b1;

endmodule

// File: tb/tb_nes_flash_rd_ctrl.sv
// Bench for nes_flash_rd_ctrl: vector table of reads through a scoreboard queue,
// plus hand sequences for reset sequencing, invalidation and mid-access reset.
module tb_nes_flash_rd_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_req;
   logic [22:0] i_fl_addr;
   logic        i_inval;
   logic [7:0]  o_rdata;
   logic        o_ready;
   logic        o_busy;
   logic [22:0] o_FL_ADDR;
   logic [7:0]  i_FL_DQ;
   logic        o_FL_CE_N;
   logic        o_FL_OE_N;
   logic        o_FL_WE_N;
   logic        o_FL_RST_N;
   logic        o_FL_WP_N;

   int checks   = 0;
   int failures = 0;

   localparam int ACC = 5;

   typedef struct {
      logic [22:0] addr;
      logic [7:0]  dq;
      logic        inv;
      bit          miss;
      logic [7:0]  rd;
   } vec_t;

   typedef struct {
      logic [7:0]  rd;
      int          lat;
      int          ce;
      logic [22:0] addr;
   } exp_t;

   vec_t vecs[9];
   exp_t sb_q[$];

   nes_flash_rd_ctrl dut (
      .i_clk      (i_clk),
      .i_rstn     (i_rstn),
      .i_req      (i_req),
      .i_fl_addr  (i_fl_addr),
      .i_inval    (i_inval),
      .o_rdata    (o_rdata),
      .o_ready    (o_ready),
      .o_busy     (o_busy),
      .o_FL_ADDR  (o_FL_ADDR),
      .i_FL_DQ    (i_FL_DQ),
      .o_FL_CE_N  (o_FL_CE_N),
      .o_FL_OE_N  (o_FL_OE_N),
      .o_FL_WE_N  (o_FL_WE_N),
      .o_FL_RST_N (o_FL_RST_N),
      .o_FL_WP_N  (o_FL_WP_N)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Releases reset and measures the flash reset pulse and recovery time.
   task automatic init_seq(input bit poke_req, input string nm);
      int low, high;
      bit pins_act, rdy;
      low = 0; high = 0; pins_act = 0; rdy = 0;
      @(negedge i_clk);
      i_rstn = 1'b1;
      while (o_FL_RST_N == 1'b0 && low < 100) begin
         @(posedge i_clk); #1;
         low++;
         i_req     = poke_req && (low == 5);
         i_fl_addr = 23'h000010;
         if (!o_FL_CE_N || !o_FL_OE_N) pins_act = 1;
         if (o_ready) rdy = 1;
      end
      i_req = 1'b0;
      while (o_busy && high < 100) begin
         @(posedge i_clk); #1;
         high++;
         if (!o_FL_CE_N || !o_FL_OE_N) pins_act = 1;
         if (o_ready) rdy = 1;
      end
      chk({nm, "_rst_low_clks"}, low, 25);
      chk({nm, "_recov_clks"}, high, 3);
      chk({nm, "_no_ce_oe"}, pins_act, 0);
      chk({nm, "_no_ready"}, rdy, 0);
   endtask

   // Issues one request, pushes its expectation, then pops and compares on o_ready.
   task automatic do_req(input logic [22:0] a, input logic [7:0] dq, input logic inv,
                         input bit miss, input logic [7:0] rd, input int inv_mid,
                         input int busy_mid, input string nm);
      int lat, ce_low, addr_bad;
      bit got;
      exp_t e;
      sb_q.push_back('{rd, (miss ? ACC : 0), (miss ? ACC : 0), a});
      i_req = 1'b1; i_fl_addr = a; i_FL_DQ = dq; i_inval = inv;
      lat = -1; ce_low = 0; addr_bad = 0; got = 0;
      while (!got && lat < 25) begin
         @(posedge i_clk); #1;
         lat++;
         i_inval   = (lat == inv_mid);
         i_req     = (lat == busy_mid);
         i_fl_addr = (lat == busy_mid) ? 23'h555555 : a;
         if (!o_FL_CE_N && !o_FL_OE_N) begin
            ce_low++;
            if (o_FL_ADDR !== a) addr_bad++;
         end
         if (o_ready) got = 1;
      end
      i_req = 1'b0; i_inval = 1'b0;
      chk({nm, "_ready_seen"}, got, 1);
      if (sb_q.size() == 0) begin
         chk({nm, "_sb_empty"}, sb_q.size(), 1);
      end else begin
         e = sb_q.pop_front();
         if (got) begin
            chk({nm, "_rdata"}, o_rdata, e.rd);
            chk({nm, "_latency"}, lat, e.lat);
            chk({nm, "_ce_oe_clks"}, ce_low, e.ce);
            chk({nm, "_fl_addr"}, addr_bad, 0);
         end
      end
   endtask

   task automatic idle_cycles(input int n, input string nm);
      int rdy, ce;
      rdy = 0; ce = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk); #1;
         if (o_ready) rdy++;
         if (!o_FL_CE_N) ce++;
      end
      chk({nm, "_no_ready"}, rdy, 0);
      chk({nm, "_no_ce"}, ce, 0);
   endtask

   initial begin
      vecs[0] = '{23'h0ABCDE, 8'h5A, 1'b0, 1'b1, 8'h5A};
      vecs[1] = '{23'h0ABCDE, 8'hFF, 1'b0, 1'b0, 8'h5A};
      vecs[2] = '{23'h0ABCDE, 8'h77, 1'b1, 1'b1, 8'h77};
      vecs[3] = '{23'h0ABCDE, 8'h11, 1'b0, 1'b0, 8'h77};
      vecs[4] = '{23'h123456, 8'hC3, 1'b0, 1'b1, 8'hC3};
      vecs[5] = '{23'h0ABCDE, 8'h22, 1'b0, 1'b1, 8'h22};
      vecs[6] = '{23'h7FFFFF, 8'h81, 1'b0, 1'b1, 8'h81};
      vecs[7] = '{23'h7FFFFF, 8'h00, 1'b0, 1'b0, 8'h81};
      vecs[8] = '{23'h000000, 8'h3C, 1'b0, 1'b1, 8'h3C};

      i_rstn = 1'b0; i_req = 1'b0; i_fl_addr = '0; i_inval = 1'b0; i_FL_DQ = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_fl_rst_n", o_FL_RST_N, 0);
      chk("rst_ce_n", o_FL_CE_N, 1);
      chk("rst_oe_n", o_FL_OE_N, 1);
      chk("rst_we_n", o_FL_WE_N, 1);
      chk("rst_wp_n", o_FL_WP_N, 1);
      chk("rst_fl_addr", o_FL_ADDR, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_busy", o_busy, 1);

      init_seq(1, "init");

      for (int i = 0; i < 9; i++)
         do_req(vecs[i].addr, vecs[i].dq, vecs[i].inv, vecs[i].miss, vecs[i].rd,
                -1, -1, $sformatf("vec%0d", i));
      idle_cycles(3, "after_vecs");

      do_req(23'h000100, 8'h42, 1'b0, 1'b1, 8'h42, 2, -1, "inval_mid_access");
      do_req(23'h000100, 8'h43, 1'b0, 1'b1, 8'h43, -1, -1, "after_inval_miss");
      do_req(23'h000100, 8'h44, 1'b0, 1'b0, 8'h43, -1, -1, "refill_hit");

      do_req(23'h000200, 8'h99, 1'b0, 1'b1, 8'h99, -1, 1, "req_while_busy");
      idle_cycles(8, "busy_req_dropped");
      do_req(23'h000200, 8'hAA, 1'b0, 1'b0, 8'h99, -1, -1, "tag_after_busy_req");

      i_inval = 1'b1;
      @(posedge i_clk); #1;
      i_inval = 1'b0;
      do_req(23'h000200, 8'h5B, 1'b0, 1'b1, 8'h5B, -1, -1, "idle_inval_miss");

      // Reset asserted with the access counter at 2.
      i_req = 1'b1; i_fl_addr = 23'h000300; i_FL_DQ = 8'h66;
      @(posedge i_clk); #1;
      i_req = 1'b0;
      repeat (2) begin @(posedge i_clk); #1; end
      chk("pre_rst_ce_low", o_FL_CE_N, 0);
      i_rstn = 1'b0;
      #1;
      chk("midrst_ce_n", o_FL_CE_N, 1);
      chk("midrst_oe_n", o_FL_OE_N, 1);
      chk("midrst_fl_rst_n", o_FL_RST_N, 0);
      chk("midrst_busy", o_busy, 1);
      chk("midrst_rdata", o_rdata, 0);
      chk("midrst_fl_addr", o_FL_ADDR, 0);
      repeat (2) @(posedge i_clk);
      init_seq(0, "reinit");
      do_req(23'h000200, 8'h12, 1'b0, 1'b1, 8'h12, -1, -1, "post_rst_prior_miss");
      idle_cycles(2, "final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
